// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one external MIPSALU between two requesters.
// Optional opcode legality check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_ctl,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_ctl,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [3:0]   alu_ctl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_out,
  output logic         rsp_zero,
  output logic         rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_reg, state_next;
  logic         last_reg;
  logic [3:0]   op_ctl_reg;
  logic [W-1:0] op_a_reg, op_b_reg;
  logic         op_id_reg;
  logic         rsp_id_reg, rsp_zero_reg;
  logic [W-1:0] rsp_out_reg;
  logic         grant_any, grant_id, hs, op_illegal;

  // Under contention the requester not served last wins; otherwise whoever is valid.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_reg : req1_valid;
  assign hs        = (state_reg == IDLE) & grant_any;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_reg;
  always_comb begin
    case (op_ctl_reg)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: op_illegal = 1'b0;
      default:                             op_illegal = 1'b1;
    endcase
  end
  assign rsp_err = rsp_err_reg;
`else
  assign op_illegal = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_ctl    = 4'd0;
    alu_a      = '0;
    alu_b      = '0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = grant_any & ~grant_id;
        req1_ready = grant_any & grant_id;
        if (grant_any) state_next = EXEC;
      end
      EXEC: begin
        alu_ctl    = op_illegal ? 4'd0 : op_ctl_reg;
        alu_a      = op_a_reg;
        alu_b      = op_b_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      op_ctl_reg   <= 4'd0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_id_reg    <= 1'b0;
      rsp_id_reg   <= 1'b0;
      rsp_out_reg  <= '0;
      rsp_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (hs) begin
        op_ctl_reg <= grant_id ? req1_ctl : req0_ctl;
        op_a_reg   <= grant_id ? req1_a   : req0_a;
        op_b_reg   <= grant_id ? req1_b   : req0_b;
        op_id_reg  <= grant_id;
        last_reg   <= grant_id;
      end
      if (state_reg == EXEC) begin
        rsp_id_reg   <= op_id_reg;
        rsp_out_reg  <= op_illegal ? '0 : alu_out;
        rsp_zero_reg <= op_illegal ? 1'b0 : alu_zero;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_ff @(posedge clock) begin
    if (reset)                   rsp_err_reg <= 1'b0;
    else if (state_reg == EXEC)  rsp_err_reg <= op_illegal;
  end
`endif

  assign rsp_id   = rsp_id_reg;
  assign rsp_out  = rsp_out_reg;
  assign rsp_zero = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; includes a behavioural MIPSALU.
// Opcode-check cases adapt when ALU_ARB_OPCHECK_EN is defined.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_ctl, req1_ctl, alu_ctl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_out;
  logic         alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.W(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // External MIPSALU stand-in
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd12:   alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Issue one op from a single requester; returns cycles from handshake to rsp_valid
  // and the ALU control seen during the execute cycle. Ends on a RESP negedge.
  task automatic do_op(input bit id, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat, output logic [3:0] exec_ctl);
    @(posedge clock); #1;
    if (id) begin req1_valid = 1'b1; req1_ctl = ctl; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_ctl = ctl; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((id ? req1_ready : req0_ready) === 1'b1) break;
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 99; exec_ctl = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) exec_ctl = alu_ctl;
      if (rsp_valid === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_zero, rsp_err} !== 6'b0)
      $display("FAIL reset_flags got=%b exp=000000",
               {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_zero, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if ({alu_ctl, alu_a, alu_b, rsp_out} !== '0)
      $display("FAIL reset_data alu_ctl=%h alu_a=%h alu_b=%h rsp_out=%h exp=0",
               alu_ctl, alu_a, alu_b, rsp_out);
    else pass_cnt++;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL reset_first_grant got=%b exp=10", {req0_ready, req1_ready});
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_sub();
    int lat; logic [3:0] ec;
    apply_reset();
    do_op(1'b0, 4'd6, 32'hD, 32'h6, lat, ec);
    total_cnt++;
    if (lat !== 2) $display("FAIL sub_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++;
    if (ec !== 4'd6) $display("FAIL sub_exec_ctl got=%0d exp=6", ec); else pass_cnt++;
    total_cnt++;
    if ({rsp_id, rsp_out, rsp_zero} !== {1'b0, 32'h7, 1'b0})
      $display("FAIL sub_rsp id=%0d out=%h zero=%0d exp id=0 out=7 zero=0", rsp_id, rsp_out, rsp_zero);
    else pass_cnt++;
    consume();
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL sub_consumed rsp_valid=%0d exp=0", rsp_valid); else pass_cnt++;
    $display("test_single_sub: id=%0d out=%h lat=%0d", rsp_id, rsp_out, lat);
  endtask

  task automatic test_zero_neg();
    int lat; logic [3:0] ec;
    do_op(1'b1, 4'd6, 32'hF, 32'hF, lat, ec);
    total_cnt++;
    if ({lat == 2, rsp_id, rsp_out, rsp_zero} !== {1'b1, 1'b1, 32'h0, 1'b1})
      $display("FAIL zero_rsp lat=%0d id=%0d out=%h zero=%0d exp lat=2 id=1 out=0 zero=1",
               lat, rsp_id, rsp_out, rsp_zero);
    else pass_cnt++;
    consume();
    do_op(1'b1, 4'd6, 32'h1, 32'h2, lat, ec);
    total_cnt++;
    if ({rsp_id, rsp_out, rsp_zero} !== {1'b1, 32'hFFFF_FFFF, 1'b0})
      $display("FAIL neg_rsp id=%0d out=%h zero=%0d exp id=1 out=ffffffff zero=0",
               rsp_id, rsp_out, rsp_zero);
    else pass_cnt++;
    consume();
    $display("test_zero_neg done");
  endtask

  task automatic test_contention();
    int  rsp_cyc [4];
    logic rsp_ids [4];
    logic [W-1:0] rsp_outs [4];
    int  k = 0;
    int  exp_cyc [4] = '{2, 5, 8, 11};
    logic [W-1:0] exp_out [4] = '{32'd2, 32'd4, 32'd2, 32'd4};
    apply_reset();
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd2; req1_b = 32'd2;
    rsp_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (n == 0 || n == 3) begin
        total_cnt++;
        if ({req0_ready, req1_ready} !== ((n == 0) ? 2'b10 : 2'b01))
          $display("FAIL cont_grant cycle=%0d got=%b exp=%b", n, {req0_ready, req1_ready},
                   (n == 0) ? 2'b10 : 2'b01);
        else pass_cnt++;
      end
      if (rsp_valid === 1'b1 && k < 4) begin
        rsp_cyc[k] = n; rsp_ids[k] = rsp_id; rsp_outs[k] = rsp_out; k++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++;
    if (k !== 4) $display("FAIL cont_count got=%0d exp=4", k); else pass_cnt++;
    for (int i = 0; i < k; i++) begin
      total_cnt++;
      if ({rsp_cyc[i], rsp_ids[i], rsp_outs[i]} !== {exp_cyc[i], i[0], exp_out[i]})
        $display("FAIL cont_rsp%0d cyc=%0d id=%0d out=%0d exp cyc=%0d id=%0d out=%0d",
                 i, rsp_cyc[i], rsp_ids[i], rsp_outs[i], exp_cyc[i], i[0], exp_out[i]);
      else pass_cnt++;
      $display("test_contention: rsp%0d id=%0d out=%0d cycle=%0d", i, rsp_ids[i], rsp_outs[i], rsp_cyc[i]);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] ec;
    apply_reset();
    do_op(1'b0, 4'd2, 32'd5, 32'd9, lat, ec);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      total_cnt++;
      if ({rsp_valid, rsp_id, rsp_out, req0_ready, req1_ready} !== {1'b1, 1'b0, 32'd14, 2'b00})
        $display("FAIL bp_hold cycle=%0d valid=%0d id=%0d out=%0d rdy=%b exp valid=1 id=0 out=14 rdy=00",
                 n, rsp_valid, rsp_id, rsp_out, {req0_ready, req1_ready});
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
      $display("FAIL bp_release valid=%0d rdy=%b exp valid=0 rdy=01",
               rsp_valid, {req0_ready, req1_ready});
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd3; req0_b = 32'd4;
    @(negedge clock);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({alu_ctl, alu_a} !== {4'd2, 32'd3})
      $display("FAIL rstmid_exec alu_ctl=%0d alu_a=%0d exp 2 3", alu_ctl, alu_a);
    else pass_cnt++;
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({rsp_valid, alu_ctl, req0_ready, req1_ready} !== {1'b0, 4'd0, 2'b10})
      $display("FAIL rstmid_idle valid=%0d alu_ctl=%0d rdy=%b exp valid=0 alu_ctl=0 rdy=10",
               rsp_valid, alu_ctl, {req0_ready, req1_ready});
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      total_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL rstmid_norsp cycle=%0d rsp_valid=%0d exp=0", n, rsp_valid);
      else pass_cnt++;
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_opcheck();
    int lat; logic [3:0] ec;
    apply_reset();
    do_op(1'b0, 4'd5, 32'd3, 32'd4, lat, ec);
`ifdef ALU_ARB_OPCHECK_EN
    total_cnt++;
    if ({ec, rsp_err, rsp_out, rsp_zero} !== {4'd0, 1'b1, 32'd0, 1'b0})
      $display("FAIL opchk_illegal exec_ctl=%0d err=%0d out=%h zero=%0d exp 0 1 0 0",
               ec, rsp_err, rsp_out, rsp_zero);
    else pass_cnt++;
`else
    total_cnt++;
    if ({ec, rsp_err, rsp_out} !== {4'd5, 1'b0, 32'd0})
      $display("FAIL opchk_forward exec_ctl=%0d err=%0d out=%h exp 5 0 0", ec, rsp_err, rsp_out);
    else pass_cnt++;
`endif
    consume();
    do_op(1'b0, 4'd7, 32'd1, 32'd2, lat, ec);
    total_cnt++;
    if ({ec, rsp_err, rsp_out} !== {4'd7, 1'b0, 32'd1})
      $display("FAIL opchk_slt exec_ctl=%0d err=%0d out=%h exp 7 0 1", ec, rsp_err, rsp_out);
    else pass_cnt++;
    consume();
    $display("test_opcheck done");
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single_sub();
    test_zero_neg();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_opcheck();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
